onn_alu_capture_bridge: RTL and testbench

- Sequential capture stage directly downstream of the ALU ONN/electronic boundary interface.
- Consumes the 29 single-bit "*_from_*" boundary inputs (ALU feedback returning from the ONN side, concatenated into one vector) and delivers them to the electronic ALU control as one stable, registered word.
- Handles the ONN request/acknowledge exchange, waits for optical settling, and requires repeated identical samples before release.
- Offers the result on a valid/ready handshake, with sticky error reporting.

---
 rtl/onn_alu_capture_bridge.sv | 133 +++++++++++++
 tb/tb_onn_alu_capture_bridge.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/onn_alu_capture_bridge.sv
// Capture stage behind the ALU ONN/electronic boundary: request, settle,
// sample until stable, then offer the word on a valid/ready handshake.
module onn_alu_capture_bridge #(
  parameter int WIDTH       = 29,
  parameter int SETTLE      = 4,
  parameter int CHECKS      = 2,
  parameter int MAX_SAMPLES = 8,
  parameter int TIMEOUT     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_req,
  output logic             cap_busy,
  output logic             onn_req,
  input  logic             onn_ack,
  input  logic [WIDTH-1:0] onn_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_unstable,
  output logic             err_timeout,
  input  logic             err_clr
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int NW = $clog2(MAX_SAMPLES + 1);
  localparam int RW = $clog2(CHECKS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SETTLE,
    S_SAMPLE,
    S_OUT
  } state_t;

  state_t           state;
  logic [TW-1:0]    timer;
  logic [SW-1:0]    settle_cnt;
  logic [NW-1:0]    cnt;
  logic [RW-1:0]    run;
  logic [WIDTH-1:0] prev;

  logic [NW-1:0]    cnt_nxt;
  logic [RW-1:0]    run_nxt;

  assign cap_busy = (state != S_IDLE);

  // Run length restarts on the first sample or on any change.
  always_comb begin
    cnt_nxt = cnt + NW'(1);
    run_nxt = RW'(1);
    if (cnt != '0 && onn_data == prev)
      run_nxt = run + RW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      timer        <= '0;
      settle_cnt   <= '0;
      cnt          <= '0;
      run          <= '0;
      prev         <= '0;
      onn_req      <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_unstable <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      // Clear first so a timeout in the same cycle overrides it.
      if (err_clr)
        err_timeout <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cap_req) begin
            state   <= S_REQ;
            onn_req <= 1'b1;
            timer   <= '0;
          end
        end
        S_REQ: begin
          if (onn_ack) begin
            state      <= S_SETTLE;
            onn_req    <= 1'b0;
            settle_cnt <= '0;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            state       <= S_IDLE;
            onn_req     <= 1'b0;
            err_timeout <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SW'(SETTLE - 1)) begin
            state <= S_SAMPLE;
            cnt   <= '0;
            run   <= '0;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        S_SAMPLE: begin
          prev <= onn_data;
          cnt  <= cnt_nxt;
          run  <= run_nxt;
          if (run_nxt == RW'(CHECKS)) begin
            state        <= S_OUT;
            out_valid    <= 1'b1;
            out_data     <= onn_data;
            out_unstable <= 1'b0;
          end else if (cnt_nxt == NW'(MAX_SAMPLES)) begin
            state        <= S_OUT;
            out_valid    <= 1'b1;
            out_data     <= onn_data;
            out_unstable <= 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state        <= S_IDLE;
            out_valid    <= 1'b0;
            out_unstable <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_onn_alu_capture_bridge.sv
// Bench for onn_alu_capture_bridge: directed table, corner sequences and
// randomized captures against a stability model.
module tb_onn_alu_capture_bridge;

  localparam int W       = 29;
  localparam int SETTLE  = 4;
  localparam int CHECKS  = 2;
  localparam int MAXS    = 8;
  localparam int TIMEOUT = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         cap_req;
  logic         cap_busy;
  logic         onn_req;
  logic         onn_ack;
  logic [W-1:0] onn_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_unstable;
  logic         err_timeout;
  logic         err_clr;

  int tests = 0;
  int fails = 0;

  onn_alu_capture_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .cap_req      (cap_req),
    .cap_busy     (cap_busy),
    .onn_req      (onn_req),
    .onn_ack      (onn_ack),
    .onn_data     (onn_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_unstable (out_unstable),
    .err_timeout  (err_timeout),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]            delay;
    logic [7:0]            rd;
    logic [0:7][W-1:0]     s;
    logic [W-1:0]          exp_data;
    logic                  exp_unst;
    logic [3:0]            exp_n;
  } tv_t;

  tv_t tv [5];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Stable once the latest CHECKS samples agree; else give up at MAXS.
  function automatic void model(input logic [0:7][W-1:0] s,
                                output int n, output logic [W-1:0] d,
                                output logic u);
    bit same;
    n = MAXS;
    d = s[MAXS-1];
    u = 1'b1;
    for (int m = CHECKS; m <= MAXS; m++) begin
      same = 1'b1;
      for (int i = m - CHECKS + 1; i < m; i++)
        if (s[i] !== s[m-CHECKS]) same = 1'b0;
      if (same) begin
        n = m;
        d = s[m-1];
        u = 1'b0;
        return;
      end
    end
  endfunction

  task automatic run_txn(input int delay, input int rd,
                         input logic [0:7][W-1:0] s,
                         input logic [W-1:0] ed, input logic eu,
                         input int en, input string tag);
    int lat;
    bit ok;
    logic [W-1:0] hd;
    cap_req = 1'b1;
    @(negedge clk);
    cap_req = 1'b0;
    chk({tag, "_req"}, {62'd0, onn_req, cap_busy}, 64'd3);
    repeat (delay) @(negedge clk);
    lat = 0;
    for (int j = 0; j < 40; j++) begin
      onn_ack = (j == 0);
      if (j >= SETTLE + 1 && j < SETTLE + 1 + MAXS)
        onn_data = s[j-SETTLE-1];
      else
        onn_data = W'($urandom);
      @(negedge clk);
      if (out_valid) begin
        lat = j + 1;
        break;
      end
    end
    onn_ack = 1'b0;
    chk({tag, "_latency"}, lat, SETTLE + 1 + en);
    if (lat == 0) return;
    chk({tag, "_data"}, out_data, ed);
    chk({tag, "_unstable"}, out_unstable, eu);
    hd = out_data;
    ok = 1'b1;
    repeat (rd) begin
      onn_data = W'($urandom);
      cap_req  = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!out_valid || out_data !== hd || out_unstable !== eu) ok = 1'b0;
    end
    cap_req = 1'b0;
    if (rd > 0) chk({tag, "_hold"}, ok, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_done"}, {61'd0, out_valid, cap_busy, out_unstable}, 64'd0);
    chk({tag, "_keep"}, out_data, ed);
  endtask

  task automatic do_timeout(input bit clr_last, input string tag);
    int c;
    cap_req = 1'b1;
    @(negedge clk);
    cap_req = 1'b0;
    c = 0;
    while (onn_req && c < 200) begin
      c++;
      if (clr_last && c == TIMEOUT) err_clr = 1'b1;
      @(negedge clk);
    end
    err_clr = 1'b0;
    chk({tag, "_cycles"}, c, TIMEOUT);
    chk({tag, "_err"}, err_timeout, 1'b1);
    chk({tag, "_idle"}, {62'd0, out_valid, cap_busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [0:7][W-1:0] rs;
    logic [W-1:0] alpha [3];
    logic [W-1:0] md;
    logic mu;
    int mn;

    rst = 1'b1;
    cap_req = 1'b0;
    onn_ack = 1'b0;
    onn_data = '0;
    out_ready = 1'b0;
    err_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", onn_req, 1'b0);
    chk("rst_busy", cap_busy, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, '0);
    chk("rst_unst", out_unstable, 1'b0);
    chk("rst_err", err_timeout, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    tv[0] = '{delay: 8'd3, rd: 8'd0, s: {8{29'h0ABCDEF}},
              exp_data: 29'h0ABCDEF, exp_unst: 1'b0, exp_n: 4'd2};
    tv[1] = '{delay: 8'd0, rd: 8'd10,
              s: {29'h1, 29'h2, 29'h1, 29'h2, 29'h1, 29'h2, 29'h1, 29'h2},
              exp_data: 29'h2, exp_unst: 1'b1, exp_n: 4'd8};
    tv[2] = '{delay: 8'd5, rd: 8'd1,
              s: {29'h5, 29'h6, 29'h6, 29'h6, 29'h6, 29'h6, 29'h6, 29'h6},
              exp_data: 29'h6, exp_unst: 1'b0, exp_n: 4'd3};
    tv[3] = '{delay: 8'd1, rd: 8'd2,
              s: {29'h1, 29'h2, 29'h3, 29'h4, 29'h5, 29'h6, 29'h7, 29'h7},
              exp_data: 29'h7, exp_unst: 1'b0, exp_n: 4'd8};
    tv[4] = '{delay: 8'd63, rd: 8'd1, s: {8{29'h1FFFFFFF}},
              exp_data: 29'h1FFFFFFF, exp_unst: 1'b0, exp_n: 4'd2};

    for (int i = 0; i < 5; i++)
      run_txn(int'(tv[i].delay), int'(tv[i].rd), tv[i].s,
              tv[i].exp_data, tv[i].exp_unst, int'(tv[i].exp_n),
              $sformatf("tv%0d", i));

    do_timeout(1'b0, "tmo1");
    run_txn(2, 0, {8{29'h123}}, 29'h123, 1'b0, 2, "after_tmo");
    chk("err_sticky", err_timeout, 1'b1);
    do_timeout(1'b1, "tmo2_setwins");
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", err_timeout, 1'b0);

    cap_req = 1'b1;
    @(negedge clk);
    cap_req = 1'b0;
    @(negedge clk);
    chk("mid_req_pre", onn_req, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_req_rst", {61'd0, onn_req, cap_busy, out_valid}, 64'd0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", cap_busy, 1'b0);
    run_txn(60, 0, {29'h9, 29'h9, 29'h0, 29'h0, 29'h0, 29'h0, 29'h0, 29'h0},
            29'h9, 1'b0, 2, "post_rst");

    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < 3; k++) alpha[k] = W'($urandom);
      for (int k = 0; k < MAXS; k++) rs[k] = alpha[$urandom_range(0, 2)];
      model(rs, mn, md, mu);
      run_txn(int'($urandom_range(0, 10)), int'($urandom_range(0, 3)),
              rs, md, mu, mn, $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
